ws2812_rx: RTL and testbench

Single-wire WS2812 receiver and decoder. It samples a WS2812-style serial line, measures the width of each high pulse to recover bits, and assembles MSB-first 24-bit colour words. Each word is presented with a one-cycle strobe and its index in the frame, and the end of a frame is flagged when the reset gap is seen. It sits at the input side of LED-chain bridges and in loopback benches opposite our WS2812 transmitter.

---
 rtl/ws2812_pkg.sv | 21 ++
 rtl/ws2812_sync.sv | 31 +++
 rtl/ws2812_rx.sv | 158 +++++++++++++++
 tb/tb_ws2812_rx.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/ws2812_pkg.sv
// Shared WS2812 definitions: receiver state encoding, word width and
// timing derivation helpers common to the receiver and the transmitter.
package ws2812_pkg;

  localparam int unsigned WORD_W    = 24;
  localparam int unsigned BIT_CNT_W = $clog2(WORD_W);

  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,
    ST_IDLE = 2'd1,
    ST_HIGH = 2'd2,
    ST_LOW  = 2'd3
  } state_t;

  // Whole clock cycles contained in ns nanoseconds at clk_mhz (truncating)
  function automatic int unsigned ns_to_cycles(input int unsigned clk_mhz,
                                               input int unsigned ns);
    return (clk_mhz * ns) / 1000;
  endfunction

endpackage

// File: rtl/ws2812_sync.sv
// Two-flop synchronizer for the asynchronous WS2812 line, plus single-cycle
// rise/fall indications derived from the synchronized value.
module ws2812_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic s_din,
  output logic rise_c,
  output logic fall_c
);

  logic meta;
  logic prev;

  // Synchronizer chain plus one history flop for edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta  <= 1'b0;
      s_din <= 1'b0;
      prev  <= 1'b0;
    end else begin
      meta  <= din;
      s_din <= meta;
      prev  <= s_din;
    end
  end

  assign rise_c = s_din & ~prev;
  assign fall_c = ~s_din & prev;

endmodule

// File: rtl/ws2812_rx.sv
// WS2812 single-wire receiver: decodes high-pulse widths into MSB-first
// 24-bit words, strobes each captured word with its frame index and flags
// the end of frame on the reset gap.
// Optional feature: define WS2812_RX_FORWARD_EN to forward the chain tail
// (pulses beyond the captured words) on dout; otherwise dout is tied 0.
module ws2812_rx
  import ws2812_pkg::*;
#(
  parameter int unsigned NUM_LEDS     = 8,
  parameter int unsigned CLK_MHZ      = 12,
  parameter int unsigned T_BIT_THRESH = ns_to_cycles(CLK_MHZ, 625),
  parameter int unsigned T_MIN_HIGH   = ns_to_cycles(CLK_MHZ, 150),
  parameter int unsigned T_MAX_HIGH   = ns_to_cycles(CLK_MHZ, 5000),
  parameter int unsigned T_RESET      = ns_to_cycles(CLK_MHZ, 50000)
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               din,
  output logic [WORD_W-1:0]                  rgb_data,
  output logic                               rgb_valid,
  output logic [$clog2(NUM_LEDS + 1)-1:0]    led_index,
  output logic                               frame_done,
  output logic                               error,
  output logic                               dout
);

  localparam int unsigned LED_BITS = $clog2(NUM_LEDS + 1);
  localparam int unsigned CNT_W    = $clog2(T_RESET + 1);

  logic                 s_din;
  logic                 rise_c;
  logic                 fall_c;
  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     cnt_inc_c;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [LED_BITS-1:0]  word_cnt;
  logic [WORD_W-2:0]    shreg;
  logic                 bit_c;
  logic                 word_last_c;
  logic                 room_c;

  ws2812_sync u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (din),
    .s_din   (s_din),
    .rise_c  (rise_c),
    .fall_c  (fall_c)
  );

  // Saturating pulse counter increment and decode helpers
  assign cnt_inc_c   = (&cnt) ? cnt : cnt + CNT_W'(1);
  assign bit_c       = (cnt > CNT_W'(T_BIT_THRESH));
  assign word_last_c = (bit_cnt == BIT_CNT_W'(WORD_W - 1));
  assign room_c      = (word_cnt < LED_BITS'(NUM_LEDS));

  // Decoder FSM: pulse measurement, bit/word assembly and output strobes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_SYNC;
      cnt        <= '0;
      bit_cnt    <= '0;
      word_cnt   <= '0;
      shreg      <= '0;
      rgb_data   <= '0;
      rgb_valid  <= 1'b0;
      led_index  <= '0;
      frame_done <= 1'b0;
      error      <= 1'b0;
    end else begin
      rgb_valid  <= 1'b0;
      frame_done <= 1'b0;
      error      <= 1'b0;
      case (state)
        ST_SYNC: begin
          if (s_din) begin
            cnt <= '0;
          end else if (cnt == CNT_W'(T_RESET)) begin
            state <= ST_IDLE;
          end else begin
            cnt <= cnt_inc_c;
          end
        end
        ST_IDLE: begin
          if (rise_c) begin
            state    <= ST_HIGH;
            cnt      <= CNT_W'(1);
            bit_cnt  <= '0;
            word_cnt <= '0;
          end
        end
        ST_HIGH: begin
          if (cnt == CNT_W'(T_MAX_HIGH)) begin
            error <= 1'b1;
            state <= ST_SYNC;
            cnt   <= '0;
          end else if (fall_c) begin
            if (cnt < CNT_W'(T_MIN_HIGH)) begin
              error <= 1'b1;
              state <= ST_SYNC;
              cnt   <= '0;
            end else begin
              state <= ST_LOW;
              cnt   <= CNT_W'(1);
              shreg <= {shreg[WORD_W-3:0], bit_c};
              if (word_last_c) begin
                bit_cnt <= '0;
                if (room_c) begin
                  rgb_data  <= {shreg, bit_c};
                  rgb_valid <= 1'b1;
                  led_index <= word_cnt;
                  word_cnt  <= word_cnt + LED_BITS'(1);
                end
              end else begin
                bit_cnt <= bit_cnt + BIT_CNT_W'(1);
              end
            end
          end else begin
            cnt <= cnt_inc_c;
          end
        end
        ST_LOW: begin
          if (cnt == CNT_W'(T_RESET)) begin
            frame_done <= 1'b1;
            error      <= (bit_cnt != '0);
            state      <= ST_IDLE;
          end else if (rise_c) begin
            state <= ST_HIGH;
            cnt   <= CNT_W'(1);
          end else begin
            cnt <= cnt_inc_c;
          end
        end
        default: begin
          state <= ST_SYNC;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef WS2812_RX_FORWARD_EN
  // Regenerate the line once every captured slot of the frame is filled
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dout <= 1'b0;
    end else if ((state == ST_HIGH || state == ST_LOW) && !room_c) begin
      dout <= s_din;
    end else begin
      dout <= 1'b0;
    end
  end
`else
  assign dout = 1'b0;
`endif

endmodule

// File: tb/tb_ws2812_rx.sv
// Directed bench for ws2812_rx at 12 MHz with two captured words per frame.
// T_MIN_HIGH is raised to 2 so that a single-cycle high pulse is a glitch.
module tb_ws2812_rx;

  localparam int unsigned NUM_LEDS = 2;
  localparam int unsigned LED_BITS = $clog2(NUM_LEDS + 1);
`ifdef WS2812_RX_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic                clk;
  logic                reset_n;
  logic                din;
  logic [23:0]         rgb_data;
  logic                rgb_valid;
  logic [LED_BITS-1:0] led_index;
  logic                frame_done;
  logic                error;
  logic                dout;

  int checks   = 0;
  int failures = 0;

  // Monitor state
  int          cyc = 0;
  int          valid_cyc = 0;
  int          done_cyc = 0;
  int          err_cyc = 0;
  int          n_done = 0;
  int          n_err = 0;
  int          n_done_err = 0;
  int          n_clash = 0;
  int          dout_bad = 0;
  int          dout_ones = 0;
  logic [31:0] vq[$];
  logic        din_d1 = 1'b0;
  logic        din_d2 = 1'b0;
  logic        fwd_win = 1'b0;
  logic        exp_dout;

  int last_fall = 0;
  int t0 = 0;

  ws2812_rx #(
    .NUM_LEDS   (NUM_LEDS),
    .CLK_MHZ    (12),
    .T_MIN_HIGH (2)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .din        (din),
    .rgb_data   (rgb_data),
    .rgb_valid  (rgb_valid),
    .led_index  (led_index),
    .frame_done (frame_done),
    .error      (error),
    .dout       (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record strobes and track forwarded-line expectation after each edge
  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    exp_dout = (FWD && fwd_win) ? din_d2 : 1'b0;
    if (dout !== exp_dout) dout_bad = dout_bad + 1;
    if (fwd_win && dout === 1'b1) dout_ones = dout_ones + 1;
    din_d2 = din_d1;
    din_d1 = din;
    if (rgb_valid === 1'b1) begin
      vq.push_back(32'({led_index, rgb_data}));
      valid_cyc = cyc;
    end
    if (frame_done === 1'b1) begin
      n_done = n_done + 1;
      done_cyc = cyc;
      if (error === 1'b1) n_done_err = n_done_err + 1;
    end
    if (error === 1'b1) begin
      n_err = n_err + 1;
      err_cyc = cyc;
    end
    if (rgb_valid === 1'b1 && error === 1'b1) n_clash = n_clash + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      failures = failures + 1;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    n_done = 0;
    n_err = 0;
    n_done_err = 0;
    vq.delete();
  endtask

  // Hold din at v for n cycles; caller is aligned to a falling clock edge
  task automatic drive(input logic v, input int n);
    din = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    drive(1'b1, b ? 10 : 5);
    last_fall = cyc;
    drive(1'b0, b ? 5 : 10);
  endtask

  task automatic send_bits(input logic [23:0] w, input int n);
    for (int i = 23; i > 23 - n; i--) send_bit(w[i]);
  endtask

  function automatic logic [31:0] vq_at(input int i);
    if (i < vq.size()) return vq[i];
    return 32'hFFFF_FFFF;
  endfunction

  initial begin
    din = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("reset_rgb_data", 32'(rgb_data), 32'h0);
    check("reset_index", 32'(led_index), 32'h0);
    check("reset_strobes", 32'({rgb_valid, frame_done, error, dout}), 32'h0);
    reset_n = 1'b1;
    drive(1'b0, 720);

    // Single word, then reset gap
    clr();
    send_bits(24'hA50F3C, 24);
    check("w1_count", 32'(vq.size()), 32'd1);
    check("w1_word", vq_at(0), 32'h00A50F3C);
    check("w1_latency", 32'(valid_cyc - last_fall), 32'd3);
    drive(1'b0, 650);
    check("w1_done", 32'(n_done), 32'd1);
    check("w1_done_latency", 32'(done_cyc - last_fall), 32'd603);
    check("w1_no_error", 32'(n_err), 32'd0);

    // Three words into two slots; third is dropped and may be forwarded
    clr();
    send_bits(24'h000001, 24);
    send_bits(24'h800000, 24);
    fwd_win = 1'b1;
    send_bits(24'hFFFFFF, 24);
    drive(1'b0, 650);
    fwd_win = 1'b0;
    check("w3_count", 32'(vq.size()), 32'd2);
    check("w3_word0", vq_at(0), 32'h00000001);
    check("w3_word1", vq_at(1), 32'h01800000);
    check("w3_done", 32'(n_done), 32'd1);
    check("w3_no_error", 32'(n_err), 32'd0);
    check("w3_dout_high_cycles", 32'(dout_ones), FWD ? 32'd240 : 32'd0);
    check("w3_dout_track", 32'(dout_bad), 32'd0);

    // Partial word: frame_done and error together, then a normal frame
    clr();
    send_bits(24'hB6D000, 10);
    drive(1'b0, 650);
    check("part_no_valid", 32'(vq.size()), 32'd0);
    check("part_done", 32'(n_done), 32'd1);
    check("part_done_with_error", 32'(n_done_err), 32'd1);
    check("part_done_latency", 32'(done_cyc - last_fall), 32'd603);
    clr();
    send_bits(24'h123456, 24);
    drive(1'b0, 650);
    check("after_part_word", vq_at(0), 32'h00123456);
    check("after_part_count", 32'(vq.size() + n_err), 32'd1);

    // Glitch mid-frame, following word ignored until a full gap
    clr();
    send_bits(24'hC3C3C3, 5);
    t0 = cyc;
    drive(1'b1, 1);
    drive(1'b0, 10);
    check("glitch_error", 32'(n_err), 32'd1);
    check("glitch_latency", 32'(err_cyc - t0), 32'd4);
    send_bits(24'hABCDEF, 24);
    drive(1'b0, 650);
    check("glitch_ignored", 32'(vq.size() + n_done), 32'd0);
    clr();
    send_bits(24'h00FF00, 24);
    drive(1'b0, 650);
    check("glitch_recover", vq_at(0), 32'h0000FF00);
    check("glitch_recover_done", 32'(n_done), 32'd1);

    // Stuck-high line
    clr();
    t0 = cyc;
    drive(1'b1, 80);
    drive(1'b0, 650);
    check("stuck_error", 32'(n_err), 32'd1);
    check("stuck_latency", 32'(err_cyc - t0), 32'd63);
    check("stuck_quiet", 32'(vq.size() + n_done), 32'd0);

    // Asynchronous reset during bit 12
    clr();
    send_bits(24'h5A5A5A, 11);
    din = 1'b1;
    repeat (3) @(negedge clk);
    check("prereset_rgb_data", 32'(rgb_data), 32'h0000FF00);
    reset_n = 1'b0;
    din = 1'b0;
    #1;
    check("async_reset_rgb_data", 32'(rgb_data), 32'h0);
    check("async_reset_outputs", 32'({led_index, rgb_valid, frame_done, error, dout}), 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    send_bits(24'h5A5A5A, 24);
    drive(1'b0, 650);
    check("postreset_ignored", 32'(vq.size() + n_done + n_err), 32'd0);
    clr();
    send_bits(24'h5A5A5A, 24);
    drive(1'b0, 650);
    check("postreset_word", vq_at(0), 32'h005A5A5A);
    check("postreset_done", 32'(n_done), 32'd1);

    check("valid_error_clash", 32'(n_clash), 32'd0);
    check("dout_track_total", 32'(dout_bad), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
